// File: rtl/mixer_cic_decim.sv
// mixer_cic_decim: real mixer followed by an N-stage CIC decimator (R = 2^RB), truncated output.
module mixer_cic_decim #(
  parameter int IB = 12,
  parameter int SB = 12,
  parameter int N  = 3,
  parameter int RB = 6,
  parameter int OB = 16,
  localparam int AW = IB + SB + N * RB
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_clock_ce,
  input  logic                 clear,
  input  logic signed [IB-1:0] adc_in,
  input  logic signed [SB-1:0] sinewave,
  output logic signed [OB-1:0] dout,
  output logic                 dout_valid
);
  logic signed [IB+SB-1:0] prod;
  logic signed [AW-1:0]    integ [N];
  logic [RB-1:0]           cnt;
  logic                    stb;
  logic [AW-OB-1:0]        unused_lsb;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prod       <= '0;
      cnt        <= '0;
      stb        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int k = 0; k < N; k++) integ[k] <= '0;
    end else if (clear) begin
      prod       <= '0;
      cnt        <= '0;
      stb        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int k = 0; k < N; k++) integ[k] <= '0;
    end else begin
      if (sample_clock_ce) begin
        prod     <= adc_in * sinewave;
        cnt      <= cnt + 1'b1;
        integ[0] <= integ[0] + {{(AW-IB-SB){prod[IB+SB-1]}}, prod};
        for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
      end
      stb        <= sample_clock_ce && (&cnt);
      dout_valid <= stb;
      if (stb) dout <= cs[N-1].y[AW-1 -: OB];
    end
  // Comb chain is purely combinational between decimated samples; only its delay taps are registered.
  for (genvar g = 0; g < N; g++) begin : cs
    logic signed [AW-1:0] x, y, dly;
    if (g == 0) begin : f
      assign x = integ[N-1];
    end else begin : f
      assign x = cs[g-1].y;
    end
    assign y = x - dly;
    always_ff @(posedge clk or posedge rst)
      if (rst) dly <= '0;
      else if (clear) dly <= '0;
      else if (stb) dly <= x;
  end
  assign unused_lsb = cs[N-1].y[AW-OB-1:0];
endmodule

// File: tb/tb_mixer_cic_decim.sv
// tb_mixer_cic_decim: checks the decimator against a zero-padded FIR model (boxcar^3 of the product stream).
module tb_mixer_cic_decim;
  localparam int R  = 64;
  localparam int HL = 3 * R - 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic ce = 1'b0;
  logic signed [11:0] adc = '0;
  logic signed [11:0] sinw = '0;
  logic signed [15:0] dout;
  logic dout_valid;
  int checks = 0, errors = 0, cyc = 0, nv = 0, pend = -1;
  longint pq[$];
  logic signed [15:0] pend_val, held;
  longint h [HL];
  typedef struct { int a; int s; int e; } vec_t;
  vec_t tv [5];

  mixer_cic_decim dut (
    .clk(clk), .rst(rst), .sample_clock_ce(ce), .clear(clear),
    .adc_in(adc), .sinewave(sinw), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0d exp %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic signed [15:0] model(input int n);
    longint y = 0;
    longint ys;
    for (int k = 0; k < HL; k++)
      if (n - 3 - k >= 1) y += h[k] * pq[n - 4 - k];
    ys = y >>> 26;
    return ys[15:0];
  endfunction

  task automatic step(input bit r, input bit cl, input bit e, input int a, input int s);
    bit ev;
    rst = r; clear = cl; ce = e; adc = 12'(a); sinw = 12'(s);
    @(posedge clk); #1; cyc++;
    if (r || cl) begin pq.delete(); pend = -1; held = '0; end
    ev = (pend == cyc);
    if (ev) held = pend_val;
    chk("valid", longint'(dout_valid), longint'(ev));
    chk("dout", longint'(dout), longint'(held));
    if (dout_valid) nv++;
    if (!r && !cl && e) begin
      pq.push_back(longint'(a) * longint'(s));
      if (pq.size() % R == 0) begin
        pend = cyc + 1;
        pend_val = model(pq.size());
      end
    end
  endtask

  initial begin
    longint b2 [2*R-1];
    for (int i = 0; i < 2*R-1; i++) b2[i] = 0;
    for (int i = 0; i < R; i++) for (int j = 0; j < R; j++) b2[i+j]++;
    for (int i = 0; i < HL; i++) h[i] = 0;
    for (int i = 0; i < 2*R-1; i++) for (int j = 0; j < R; j++) h[i+j] += b2[i];
    tv = '{'{100, 2046, 799}, '{-100, 2046, -800}, '{0, 2046, 0},
           '{2047, 2047, 16368}, '{-2048, -2048, 16384}};
    held = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_dout", longint'(dout), 0);
    chk("rst_valid", longint'(dout_valid), 0);
    step(1, 0, 1, 100, 2046);
    step(1, 0, 1, 100, 2046);
    step(0, 0, 0, 0, 0);
    // DC table: settled value after a full filter window
    foreach (tv[i]) begin
      step(0, 1, 0, 0, 0);
      for (int j = 0; j < 4 * R + 2; j++) step(0, 0, 1, tv[i].a, tv[i].s);
      chk("tbl_settled", longint'(dout), longint'(tv[i].e));
    end
    // zero input, 1000 enables
    step(0, 1, 0, 0, 0);
    nv = 0;
    for (int j = 0; j < 1000; j++) step(0, 0, 1, 0, 2046);
    chk("zero_cnt", nv, 15);
    // gapped enable, 1 in 4
    step(0, 1, 0, 0, 0);
    nv = 0;
    for (int j = 0; j < 640; j++) begin
      step(0, 0, 1, 100, 2046);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
    end
    chk("gap_cnt", nv, 10);
    chk("gap_dout", longint'(dout), 799);
    // async reset mid-decimation while output is non-zero
    for (int j = 0; j < 40; j++) step(0, 0, 1, 100, 2046);
    rst = 1'b1;
    #2;
    chk("arst_dout", longint'(dout), 0);
    chk("arst_valid", longint'(dout_valid), 0);
    step(1, 0, 1, 100, 2046);
    step(1, 0, 1, 100, 2046);
    step(0, 0, 0, 0, 0);
    nv = 0;
    for (int j = 0; j < 64; j++) step(0, 0, 1, 100, 2046);
    chk("rst_pre_cnt", nv, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_cnt", nv, 1);
    // clear right after a wrapping enable cancels its strobe
    step(0, 1, 0, 0, 0);
    for (int j = 0; j < 192; j++) step(0, 0, 1, 100, 2046);
    nv = 0;
    step(0, 1, 1, 100, 2046);
    step(0, 0, 0, 0, 0);
    chk("clr_cancel", nv, 0);
    for (int j = 0; j < 3 * R + 2; j++) step(0, 0, 1, 100, 2046);
    chk("clr_settle", longint'(dout), 799);
    // randomized traffic
    for (int j = 0; j < 1500; j++)
      step(0, $urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mixer_cic_decim.md
MIXER_CIC_DECIM -- requirements
Module: mixer_cic_decim

Interface
REQ-001 SHALL have parameter IB, default 12: signed ADC sample width.
REQ-002 SHALL have parameter SB, default 12: signed local-oscillator (sine) width.
REQ-003 SHALL have parameter N, default 3: number of CIC integrator/comb stages (differential delay 1).
REQ-004 SHALL have parameter RB, default 6: log2 of decimation ratio R (R = 2^RB = 64).
REQ-005 SHALL have parameter OB, default 16: signed output width.
REQ-006 SHALL have derived width AW = IB+SB+N*RB (42 at defaults) for all integrator and comb registers.
REQ-007 clk  input  1  clock; all state changes on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 sample_clock_ce  input  1  sample-rate clock enable; one input sample per high cycle.
REQ-010 clear  input  1  synchronous flush of all datapath state, higher priority than sample_clock_ce.
REQ-011 adc_in  input  IB  signed ADC sample, valid in cycles where sample_clock_ce=1.
REQ-012 sinewave  input  SB  signed LO sample from the sine generator, valid in cycles where sample_clock_ce=1.
REQ-013 dout  output  OB  signed decimated baseband sample.
REQ-014 dout_valid  output  1  single-cycle strobe marking a new dout.

Function
REQ-015 Mixer: on each clk with sample_clock_ce=1, product register SHALL load the full-precision signed product adc_in*sinewave (IB+SB bits).
REQ-016 Integrators: on each clk with sample_clock_ce=1, stage 1 SHALL add the sign-extended product register and stage k SHALL add the pre-update value of stage k-1, all modulo 2^AW, with wrap-around permitted and no saturation.
REQ-017 Decimation counter (RB bits) SHALL increment on each sample_clock_ce and wrap from R-1 to 0; a wrap SHALL raise an internal decimation strobe.
REQ-018 On the decimation strobe, the last integrator SHALL be sampled into the comb chain; the comb chain SHALL compute y_k = x_k - x_k(previous decimated sample) per stage, modulo 2^AW, in one registered pipeline step.
REQ-019 dout SHALL equal comb output bits [AW-1 : AW-OB] (truncation toward negative infinity, no rounding).
REQ-020 dout_valid SHALL pulse high for exactly one clk, 2 clk cycles after the sample_clock_ce cycle on which the counter wrapped; dout SHALL be updated in that same cycle and held until the next strobe.
REQ-021 Exactly one dout_valid SHALL occur per R sample_clock_ce pulses, independent of gaps between enables.
REQ-022 A clk with sample_clock_ce=0 SHALL leave the product, integrators and counter unchanged; the comb pipeline SHALL still advance.
REQ-023 clear=1 SHALL zero product, integrators, combs, comb delay registers, counter, dout and dout_valid on the next edge, regardless of sample_clock_ce; pipelined strobes in flight SHALL be cancelled.
REQ-024 No backpressure: the consumer SHALL accept dout whenever dout_valid=1.

Reset
REQ-025 While rst=1, all registers SHALL be 0 immediately: dout=0, dout_valid=0, counter=0, integrators, combs, delays and product=0.
REQ-026 After rst deasserts, the first dout_valid SHALL follow the R-th sample_clock_ce pulse after reset.
REQ-027 rst asserted mid-decimation SHALL discard the partial accumulation; no dout_valid SHALL be emitted for it.

Verification
REQ-028 Zero input: adc_in=0, sinewave=12'h7FE, ce every cycle, 1000 cycles -> every dout=0, dout_valid count 15.
REQ-029 DC gain: adc_in=100, sinewave=12'h7FE (2046), ce every cycle -> from the 3rd dout_valid onward dout=799 (204600*2^18/2^26 floored).
REQ-030 Negative DC: adc_in=-100, sinewave=12'h7FE -> settled dout=-800.
REQ-031 Gapped enable: sample_clock_ce high 1 cycle in 4, 640 pulses -> exactly 10 dout_valid pulses, each one cycle wide, each 2 clks after the wrapping enable.
REQ-032 Mid-run rst: assert rst after 40 enables, release, apply 64 more enables -> exactly one dout_valid, at the 64th enable +2 clks; all outputs 0 during rst.
REQ-033 Mid-run clear with DC input as in REQ-029 -> next edge dout=0, dout_valid=0, pending strobe cancelled; settled dout returns to 799 after 3 further strobes.
